// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial unsigned magnitude comparator: one 1-bit compare stage walks the operands MSB first.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN ends the walk at the first differing bit.
module serial_mag_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [IDX_W-1:0]   idx_q;
    logic               decided_q, gt_int_q;
    logic               busy_q, done_q, gt_q, eq_q, lt_q;

    logic               a_bit, b_bit, bit_diff;
    logic               decided_d, gt_int_d;
    logic               finish;

    // Explicit select loop keeps the index mux lint-clean even when WIDTH is 1.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bit_diff  = a_bit ^ b_bit;
        decided_d = decided_q | bit_diff;
        gt_int_d  = decided_q ? gt_int_q : (bit_diff & a_bit);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish    = (idx_q == '0) | (bit_diff & ~decided_q);
`else
        finish    = (idx_q == '0);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_int_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        idx_q     <= IDX_W'(WIDTH - 1);
                        decided_q <= 1'b0;
                        gt_int_q  <= 1'b0;
                        gt_q      <= 1'b0;
                        eq_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    decided_q <= decided_d;
                    gt_int_q  <= gt_int_d;
                    if (finish) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gt_q    <= decided_d & gt_int_d;
                        lt_q    <= decided_d & ~gt_int_d;
                        eq_q    <= ~decided_d;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Self-checking bench for serial_mag_comparator_ctrl: WIDTH=8 and WIDTH=1 instances vs an arithmetic model.
module tb_serial_mag_comparator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, gt8, eq8, lt8;
    logic       busy1, done1, gt1, eq1, lt1;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] R_GT = 3'b100, R_EQ = 3'b010, R_LT = 3'b001;

    always #5 clk = ~clk;

    serial_mag_comparator_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
    );

    serial_mag_comparator_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic o_busy(input bit w1);
        return w1 ? busy1 : busy8;
    endfunction

    function automatic logic o_done(input bit w1);
        return w1 ? done1 : done8;
    endfunction

    function automatic logic [2:0] o_res(input bit w1);
        return w1 ? {gt1, eq1, lt1} : {gt8, eq8, lt8};
    endfunction

    // Reference: verdict from plain unsigned arithmetic, latency from the position of the top differing bit.
    function automatic logic [2:0] ref_res(input int w, input logic [7:0] av, input logic [7:0] bv);
        int x = int'(av) % (1 << w);
        int y = int'(bv) % (1 << w);
        if (x > y) return R_GT;
        if (x < y) return R_LT;
        return R_EQ;
    endfunction

    function automatic int ref_lat(input int w, input logic [7:0] av, input logic [7:0] bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = w - 1; i >= 0; i--)
            if (av[i] != bv[i]) return w - i;
`endif
        return w;
    endfunction

    task automatic drive(input bit w1, input logic st, input logic [7:0] av, input logic [7:0] bv);
        if (w1) begin
            start1 = st; a1 = av[0]; b1 = bv[0];
        end else begin
            start8 = st; a8 = av; b8 = bv;
        end
    endtask

    // Called at the negedge following the accept edge; steps edge by edge until done.
    task automatic wait_done(input bit w1, input int exp_lat, input logic [2:0] exp_res, input string tag);
        bit seen = 1'b0;
        for (int n = 1; n <= exp_lat + 3 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_done(w1)) begin
                seen = 1'b1;
                check({tag, "_lat"}, n, exp_lat);
                check({tag, "_res"}, o_res(w1), exp_res);
                check({tag, "_busy_in_done"}, o_busy(w1), 1'b0);
            end else if (n < exp_lat) begin
                check({tag, "_busy_run"}, o_busy(w1), 1'b1);
            end
        end
        if (!seen) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic run_cmp(input bit w1, input logic [7:0] av, input logic [7:0] bv, input string tag);
        int w = w1 ? 1 : 8;
        logic [2:0] er = ref_res(w, av, bv);
        @(negedge clk);
        drive(w1, 1'b1, av, bv);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs while busy: they must not affect the latched operands.
        drive(w1, 1'b0, 8'($urandom), 8'($urandom));
        check({tag, "_busy_start"}, o_busy(w1), 1'b1);
        check({tag, "_cleared"}, o_res(w1), 3'b000);
        wait_done(w1, ref_lat(w, av, bv), er, tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, o_done(w1), 1'b0);
        check({tag, "_hold"}, o_res(w1), er);
    endtask

    initial begin
        #12;
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_res8", {gt8, eq8, lt8}, 3'b000);
        check("rst_res1", {busy1, done1, gt1, eq1, lt1}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(1'b0, 8'hA5, 8'hA5, "eq_a5");
        repeat (3) @(negedge clk);
        check("eq_a5_long_hold", {gt8, eq8, lt8}, R_EQ);
        run_cmp(1'b0, 8'h80, 8'h7F, "gt_80");
        run_cmp(1'b0, 8'h12, 8'h13, "lt_12");
        run_cmp(1'b0, 8'h00, 8'hFF, "lt_00");
        run_cmp(1'b0, 8'hFF, 8'hFE, "gt_ff");

        // Start held high across two compares; operands change during the first RUN.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h05, 8'h03);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h01, 8'h09);
        wait_done(1'b0, ref_lat(8, 8'h05, 8'h03), R_GT, "held1");
        @(posedge clk);
        @(negedge clk);
        check("held_idle_busy", busy8, 1'b0);
        check("held_idle_res", {gt8, eq8, lt8}, R_GT);
        @(posedge clk);
        @(negedge clk);
        check("held_accept_busy", busy8, 1'b1);
        check("held_accept_clr", {gt8, eq8, lt8}, 3'b000);
        start8 = 1'b0;
        wait_done(1'b0, ref_lat(8, 8'h01, 8'h09), R_LT, "held2");

        // Asynchronous reset three cycles into RUN.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", {busy8, done8, gt8, eq8, lt8}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("arst_no_done", {busy8, done8}, 2'b00);
        end
        run_cmp(1'b0, 8'h40, 8'h40, "post_rst");

        for (int k = 0; k < 20; k++) begin
            logic [7:0] ra = 8'($urandom);
            logic [7:0] rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            run_cmp(1'b0, ra, rb, "rand8");
        end

        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk = 2'(k);
            run_cmp(1'b1, {7'd0, kk[1]}, {7'd0, kk[0]}, "w1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
